// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit with register scoreboard for variable-latency ops, load-use check and redirect flush.
// Optional perf counters (PERF_stall_cycles / PERF_flush_cycles) enabled by defining HZD_PERF_CNT_EN.
module hazard_scoreboard #(
   parameter int REG_ADDR_W  = 5,
   parameter int MAX_OUT     = 4,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ID_valid,
   input  logic [REG_ADDR_W-1:0] ID_rs1,
   input  logic [REG_ADDR_W-1:0] ID_rs2,
   input  logic [REG_ADDR_W-1:0] ID_rd,
   input  logic                  ID_long,
   input  logic                  EXEC_mem2reg,
   input  logic [REG_ADDR_W-1:0] EXEC_rd,
   input  logic                  BRA,
   input  logic                  JMP,
   input  logic                  LL_done,
   input  logic [REG_ADDR_W-1:0] LL_rd,
   output logic                  ID_stall,
   output logic                  ID_flush,
   output logic                  EXEC_flush,
   output logic                  FWD_ll_rs1,
   output logic                  FWD_ll_rs2,
   output logic                  SB_busy,
`ifdef HZD_PERF_CNT_EN
   output logic                  SB_err,
   output logic [31:0]           PERF_stall_cycles,
   output logic [31:0]           PERF_flush_cycles
`else
   output logic                  SB_err
`endif
);

   localparam int NREG  = 2 ** REG_ADDR_W;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [NREG-1:1]   r_pending;
   logic [CNT_W-1:0]  r_out_cnt;
   logic [2:0]        r_flush_cnt;
   logic              r_err;

   logic [NREG-1:0]   w_pend_full;
   logic [NREG-1:1]   w_pend_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_redirect;
   logic              w_clr_rs1, w_clr_rs2, w_clr_rd;
   logic              w_pnd_rs1, w_pnd_rs2, w_pnd_rd, w_pnd_ll;
   logic              w_raw, w_luse, w_waw, w_cap;
   logic              w_issue;
   logic              w_done_bad;

   // Bit 0 is a constant zero so x0 lookups need no special case.
   assign w_pend_full = {r_pending, 1'b0};

   assign w_pnd_rs1 = w_pend_full[ID_rs1];
   assign w_pnd_rs2 = w_pend_full[ID_rs2];
   assign w_pnd_rd  = w_pend_full[ID_rd];
   assign w_pnd_ll  = w_pend_full[LL_rd];

   assign w_clr_rs1 = LL_done && (LL_rd == ID_rs1) && (ID_rs1 != '0);
   assign w_clr_rs2 = LL_done && (LL_rd == ID_rs2) && (ID_rs2 != '0);
   assign w_clr_rd  = LL_done && (LL_rd == ID_rd)  && (ID_rd  != '0);

   assign w_redirect = BRA | JMP;
   assign ID_flush   = w_redirect | (r_flush_cnt != '0);

   // A register completing this cycle is no longer a hazard (bypass from the LL bus).
   assign w_raw  = ((ID_rs1 != '0) && w_pnd_rs1 && !w_clr_rs1) ||
                   ((ID_rs2 != '0) && w_pnd_rs2 && !w_clr_rs2);
   assign w_luse = EXEC_mem2reg && (EXEC_rd != '0) &&
                   ((EXEC_rd == ID_rs1) || (EXEC_rd == ID_rs2));
   assign w_waw  = ID_long && (ID_rd != '0) && w_pnd_rd && !w_clr_rd;
   assign w_cap  = ID_long && (r_out_cnt == CNT_W'(MAX_OUT)) && !LL_done;

   assign ID_stall   = ID_valid && !ID_flush && (w_raw || w_luse || w_waw || w_cap);
   assign EXEC_flush = w_redirect | ID_stall;
   assign w_issue    = ID_valid && !ID_flush && !ID_stall && ID_long;

   assign FWD_ll_rs1 = ID_valid && (ID_rs1 != '0) && w_clr_rs1 && w_pnd_rs1;
   assign FWD_ll_rs2 = ID_valid && (ID_rs2 != '0) && w_clr_rs2 && w_pnd_rs2;

   assign SB_busy = (r_out_cnt != '0);
   assign SB_err  = r_err;

   assign w_done_bad = LL_done && ((r_out_cnt == '0) || ((LL_rd != '0) && !w_pnd_ll));

   // Set from a same-cycle issue takes priority over the completion clear.
   always_comb begin
      w_pend_nxt = r_pending;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (w_issue && (ID_rd == REG_ADDR_W'(i)))
            w_pend_nxt[i] = 1'b1;
         else if (LL_done && (LL_rd == REG_ADDR_W'(i)))
            w_pend_nxt[i] = 1'b0;
      end
   end

   always_comb begin
      w_cnt_nxt = r_out_cnt;
      if (w_issue && !(LL_done && (r_out_cnt != '0)))
         w_cnt_nxt = r_out_cnt + 1'b1;
      else if (!w_issue && LL_done && (r_out_cnt != '0))
         w_cnt_nxt = r_out_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= '0;
         r_out_cnt   <= '0;
         r_flush_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         r_out_cnt <= w_cnt_nxt;
         if (w_redirect)
            r_flush_cnt <= 3'(FLUSH_DEPTH);
         else if (r_flush_cnt != '0)
            r_flush_cnt <= r_flush_cnt - 3'd1;
         if (w_done_bad)
            r_err <= 1'b1;
      end
   end

`ifdef HZD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         PERF_stall_cycles <= '0;
         PERF_flush_cycles <= '0;
      end else begin
         if (ID_stall)
            PERF_stall_cycles <= PERF_stall_cycles + 32'd1;
         if (ID_flush)
            PERF_flush_cycles <= PERF_flush_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; perf counter checks compiled in when HZD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       ID_valid, ID_long, EXEC_mem2reg, BRA, JMP, LL_done;
   logic [4:0] ID_rs1, ID_rs2, ID_rd, EXEC_rd, LL_rd;
   logic       ID_stall, ID_flush, EXEC_flush, FWD_ll_rs1, FWD_ll_rs2, SB_busy, SB_err;
`ifdef HZD_PERF_CNT_EN
   logic [31:0] PERF_stall_cycles, PERF_flush_cycles;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_ADDR_W(5), .MAX_OUT(4), .FLUSH_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd), .ID_long(ID_long),
      .EXEC_mem2reg(EXEC_mem2reg), .EXEC_rd(EXEC_rd), .BRA(BRA), .JMP(JMP),
      .LL_done(LL_done), .LL_rd(LL_rd),
      .ID_stall(ID_stall), .ID_flush(ID_flush), .EXEC_flush(EXEC_flush),
      .FWD_ll_rs1(FWD_ll_rs1), .FWD_ll_rs2(FWD_ll_rs2), .SB_busy(SB_busy),
`ifdef HZD_PERF_CNT_EN
      .SB_err(SB_err), .PERF_stall_cycles(PERF_stall_cycles), .PERF_flush_cycles(PERF_flush_cycles)
`else
      .SB_err(SB_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      ID_valid = 0; ID_long = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0;
      EXEC_mem2reg = 0; EXEC_rd = 0; BRA = 0; JMP = 0; LL_done = 0; LL_rd = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      #2;
      chk("rst_stall", {31'd0, ID_stall}, 32'd0);
      chk("rst_flush", {31'd0, ID_flush}, 32'd0);
      chk("rst_xflush", {31'd0, EXEC_flush}, 32'd0);
      chk("rst_busy", {31'd0, SB_busy}, 32'd0);
      chk("rst_err", {31'd0, SB_err}, 32'd0);
      chk("rst_fwd", {30'd0, FWD_ll_rs1, FWD_ll_rs2}, 32'd0);

      // RAW on a long-latency destination, released by completion bypass
      tick();
      ID_valid = 1; ID_long = 1; ID_rd = 5; #2;
      chk("t1_issue_stall", {31'd0, ID_stall}, 32'd0);
      tick();
      ID_long = 0; ID_rs1 = 5; #2;
      chk("t1_raw_stall", {31'd0, ID_stall}, 32'd1);
      chk("t1_raw_xflush", {31'd0, EXEC_flush}, 32'd1);
      chk("t1_busy", {31'd0, SB_busy}, 32'd1);
      chk("t1_nofwd", {31'd0, FWD_ll_rs1}, 32'd0);
      tick(); #2;
      chk("t1_raw_stall2", {31'd0, ID_stall}, 32'd1);
      tick();
      LL_done = 1; LL_rd = 5; #2;
      chk("t1_done_stall", {31'd0, ID_stall}, 32'd0);
      chk("t1_fwd_rs1", {31'd0, FWD_ll_rs1}, 32'd1);
      chk("t1_fwd_rs2", {31'd0, FWD_ll_rs2}, 32'd0);
      tick();
      idle(); #2;
      chk("t1_idle_busy", {31'd0, SB_busy}, 32'd0);
      chk("t1_err", {31'd0, SB_err}, 32'd0);
`ifdef HZD_PERF_CNT_EN
      chk("t1_perf_stall", PERF_stall_cycles, 32'd2);
`endif

      // capacity: four outstanding, fifth issues only alongside a completion
      ID_valid = 1; ID_long = 1;
      for (int r = 1; r <= 4; r++) begin
         ID_rd = 5'(r); #2;
         chk("t2_fill_stall", {31'd0, ID_stall}, 32'd0);
         tick();
      end
      ID_rd = 6; #2;
      chk("t2_cap_stall", {31'd0, ID_stall}, 32'd1);
      chk("t2_busy", {31'd0, SB_busy}, 32'd1);
      LL_done = 1; LL_rd = 1; #2;
      chk("t2_cap_release", {31'd0, ID_stall}, 32'd0);
      tick();
      LL_done = 0; ID_rd = 7; ID_rs1 = 1; #2;
      chk("t2_cnt_held", {31'd0, ID_stall}, 32'd1);
      idle();
      for (int r = 2; r <= 4; r++) begin
         LL_done = 1; LL_rd = 5'(r);
         tick();
      end
      LL_rd = 6; #2;
      chk("t2_last_busy", {31'd0, SB_busy}, 32'd1);
      tick();
      idle(); #2;
      chk("t2_drain_busy", {31'd0, SB_busy}, 32'd0);
      chk("t2_drain_err", {31'd0, SB_err}, 32'd0);

      // redirect flush: BRA gives 3 cycles, later JMP restarts the count
      BRA = 1; ID_valid = 1; EXEC_mem2reg = 1; EXEC_rd = 7; ID_rs2 = 7; #2;
      chk("t3_bra_flush", {31'd0, ID_flush}, 32'd1);
      chk("t3_bra_xflush", {31'd0, EXEC_flush}, 32'd1);
      chk("t3_bra_nostall", {31'd0, ID_stall}, 32'd0);
      tick();
      BRA = 0; #2;
      chk("t3_c1_flush", {31'd0, ID_flush}, 32'd1);
      chk("t3_c1_nostall", {31'd0, ID_stall}, 32'd0);
      chk("t3_c1_xflush", {31'd0, EXEC_flush}, 32'd0);
      idle();
      tick(); #2;
      chk("t3_c2_flush", {31'd0, ID_flush}, 32'd1);
      tick(); #2;
      chk("t3_c3_flush", {31'd0, ID_flush}, 32'd0);
      BRA = 1; tick();
      BRA = 0; tick();
      JMP = 1; #2;
      chk("t3_jmp_flush", {31'd0, ID_flush}, 32'd1);
      tick();
      JMP = 0; tick(); #2;
      chk("t3_c4_flush", {31'd0, ID_flush}, 32'd1);
      tick(); #2;
      chk("t3_c5_flush", {31'd0, ID_flush}, 32'd0);
`ifdef HZD_PERF_CNT_EN
      chk("t3_perf_flush", PERF_flush_cycles, 32'd8);
`endif

      // load-use
      ID_valid = 1; EXEC_mem2reg = 1; EXEC_rd = 7; ID_rs2 = 7; #2;
      chk("t4_luse_stall", {31'd0, ID_stall}, 32'd1);
      chk("t4_luse_xflush", {31'd0, EXEC_flush}, 32'd1);
      EXEC_rd = 0; ID_rs2 = 0; #2;
      chk("t4_exrd0", {31'd0, ID_stall}, 32'd0);
      EXEC_rd = 7; #2;
      chk("t4_rs2_0", {31'd0, ID_stall}, 32'd0);
      idle();
      tick();

      // x0 destination counts but never pends; bad completion is sticky
      ID_valid = 1; ID_long = 1; ID_rd = 0;
      tick();
      ID_long = 0; #2;
      chk("t5_x0_busy", {31'd0, SB_busy}, 32'd1);
      chk("t5_x0_nostall", {31'd0, ID_stall}, 32'd0);
      ID_long = 1; #2;
      chk("t5_x0_nowaw", {31'd0, ID_stall}, 32'd0);
      idle();
      LL_done = 1; LL_rd = 0;
      tick();
      LL_done = 0; #2;
      chk("t5_x0_done_busy", {31'd0, SB_busy}, 32'd0);
      chk("t5_x0_done_err", {31'd0, SB_err}, 32'd0);
      LL_done = 1; LL_rd = 3;
      tick();
      LL_done = 0; #2;
      chk("t5_err_set", {31'd0, SB_err}, 32'd1);
      chk("t5_err_cnt", {31'd0, SB_busy}, 32'd0);
      tick(); tick(); #2;
      chk("t5_err_sticky", {31'd0, SB_err}, 32'd1);
      rst = 1;
      tick();
      rst = 0; #2;
      chk("t5_err_rst", {31'd0, SB_err}, 32'd0);
`ifdef HZD_PERF_CNT_EN
      chk("t5_perf_stall_rst", PERF_stall_cycles, 32'd0);
      chk("t5_perf_flush_rst", PERF_flush_cycles, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
